reflet_vga_compositor: RTL and testbench

- Parametrised N-layer pixel compositor placed between the VGA timing generator and the DAC pins.
- Receives one RGBA sample per layer per clock plus the sync/blank signals from the timing generator. Blends the layers bottom-to-top over a background colour with real α blending and outputs RGB.
- Sync and blank are delayed to stay aligned with the colour outputs.
- Per-layer enable and global α are CPU-written and take effect only at the start of vertical sync, so a frame never tears.

---
 rtl/reflet_vga_compositor_if.sv | 41 ++++
 rtl/reflet_vga_compositor.sv | 200 ++++++++++++++++++++
 tb/tb_reflet_vga_compositor.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/reflet_vga_compositor_if.sv
// Signal bundle for reflet_vga_compositor: timing-generator video in,
// CPU configuration writes, and composited video out toward the DAC.
interface reflet_vga_compositor_if #(
  parameter int n_layers    = 2,
  parameter int color_depth = 8
);
  localparam int LW = (n_layers > 1) ? $clog2(n_layers) : 1;

  // video in
  logic                              h_sync_in;
  logic                              v_sync_in;
  logic                              blank_in;
  logic [n_layers*4*color_depth-1:0] layers_in;

  // configuration writes
  logic                              cfg_we;
  logic [LW-1:0]                     cfg_layer;
  logic                              cfg_en;
  logic [color_depth-1:0]            cfg_alpha;
  logic                              bg_we;
  logic [3*color_depth-1:0]          bg_rgb;

  // video out
  logic                              h_sync;
  logic                              v_sync;
  logic [color_depth-1:0]            R_out;
  logic [color_depth-1:0]            G_out;
  logic [color_depth-1:0]            B_out;

  modport slave (
    input  h_sync_in, v_sync_in, blank_in, layers_in,
    input  cfg_we, cfg_layer, cfg_en, cfg_alpha, bg_we, bg_rgb,
    output h_sync, v_sync, R_out, G_out, B_out
  );

  modport master (
    output h_sync_in, v_sync_in, blank_in, layers_in,
    output cfg_we, cfg_layer, cfg_en, cfg_alpha, bg_we, bg_rgb,
    input  h_sync, v_sync, R_out, G_out, B_out
  );
endinterface

// File: rtl/reflet_vga_compositor.sv
// N-layer alpha compositor between the VGA timing generator and the DAC.
// Pipeline: stage 0 (input + config sample), stage 1 (effective alpha),
// one blend stage per layer bottom-to-top, then the output register.
// Latency from input sample edge to output edge is n_layers+2 clocks.
module reflet_vga_compositor #(
  parameter int   n_layers    = 2,
  parameter int   color_depth = 8,
  parameter logic sync_active = 1'b0
) (
  input logic                    clk,
  input logic                    reset,
  reflet_vga_compositor_if.slave bus
);
  localparam int            NL        = n_layers;
  localparam int            CD        = color_depth;
  localparam int            LW        = (NL > 1) ? $clog2(NL) : 1;
  localparam int            SW        = 2*CD + 1;
  localparam logic [CD-1:0] MAX       = '1;
  localparam logic [CD-1:0] HALF      = MAX >> 1;
  localparam logic          SYNC_IDLE = ~sync_active;

  // round((w*x + (max-w)*y) / max); max is odd so there are never ties,
  // and adding floor(max/2) before the floor-divide gives exact rounding.
  // With y=0 this is round(w*x/max), used for the effective alpha.
  function automatic logic [CD-1:0] mix(input logic [CD-1:0] w,
                                        input logic [CD-1:0] x,
                                        input logic [CD-1:0] y);
    logic [SW-1:0] sum;
    sum = SW'(w) * SW'(x) + SW'(MAX - w) * SW'(y) + SW'(HALF);
    return CD'(sum / SW'(MAX));
  endfunction

  // configuration: pending (CPU written) and active (frame-stable) sets
  logic [NL-1:0]    pend_en_q, pend_en_d, act_en_q, act_en_d;
  logic [NL*CD-1:0] pend_ga_q, pend_ga_d, act_ga_q, act_ga_d;
  logic [3*CD-1:0]  pend_bg_q, pend_bg_d, act_bg_q, act_bg_d;
  logic             vs_prev_q, vs_prev_d;
  logic             commit;

  // stage 0
  logic                s0_h_q, s0_h_d, s0_v_q, s0_v_d, s0_blank_q, s0_blank_d;
  logic [NL*4*CD-1:0]  s0_px_q, s0_px_d;
  logic [NL-1:0]       s0_en_q, s0_en_d;
  logic [NL*CD-1:0]    s0_ga_q, s0_ga_d;
  logic [3*CD-1:0]     s0_bg_q, s0_bg_d;

  // stage 1 is index 0; index k+1 holds the accumulator after layer k
  logic [NL:0]         st_h_q, st_h_d, st_v_q, st_v_d, st_blank_q, st_blank_d;
  logic [3*CD-1:0]     st_acc_q [NL+1];
  logic [3*CD-1:0]     st_acc_d [NL+1];
  logic [NL*3*CD-1:0]  st_fg_q  [NL];
  logic [NL*3*CD-1:0]  st_fg_d  [NL];
  logic [NL*CD-1:0]    st_ea_q  [NL];
  logic [NL*CD-1:0]    st_ea_d  [NL];

  // output register, colour packed {B,G,R}
  logic                h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic [3*CD-1:0]     rgb_q, rgb_d;

  // Pending writes and the sync-start commit; a write on the commit clock
  // only reaches pending, the active set takes the previous pending value.
  always_comb begin
    commit    = (bus.v_sync_in == sync_active) && (vs_prev_q != sync_active);
    vs_prev_d = bus.v_sync_in;
    pend_en_d = pend_en_q;
    pend_ga_d = pend_ga_q;
    pend_bg_d = pend_bg_q;
    for (int i = 0; i < NL; i++) begin
      if (bus.cfg_we && (bus.cfg_layer == LW'(i))) begin
        pend_en_d[i]          = bus.cfg_en;
        pend_ga_d[i*CD +: CD] = bus.cfg_alpha;
      end
    end
    if (bus.bg_we) pend_bg_d = bus.bg_rgb;
    act_en_d = commit ? pend_en_q : act_en_q;
    act_ga_d = commit ? pend_ga_q : act_ga_q;
    act_bg_d = commit ? pend_bg_q : act_bg_q;
  end

  // Stage 0 takes the configuration that is active from this edge on, so
  // the pixel entering on the commit edge already sees the new set.
  always_comb begin
    s0_h_d     = bus.h_sync_in;
    s0_v_d     = bus.v_sync_in;
    s0_blank_d = bus.blank_in;
    s0_px_d    = bus.layers_in;
    s0_en_d    = act_en_d;
    s0_ga_d    = act_ga_d;
    s0_bg_d    = act_bg_d;
  end

  // Effective alpha, then one blend per layer over the running accumulator.
  always_comb begin
    st_h_d     = '0;
    st_v_d     = '0;
    st_blank_d = '0;
    for (int j = 0; j <= NL; j++) st_acc_d[j] = '0;
    for (int j = 0; j < NL; j++) begin
      st_fg_d[j] = '0;
      st_ea_d[j] = '0;
    end

    st_h_d[0]     = s0_h_q;
    st_v_d[0]     = s0_v_q;
    st_blank_d[0] = s0_blank_q;
    st_acc_d[0]   = s0_bg_q;
    for (int i = 0; i < NL; i++) begin
      st_fg_d[0][i*3*CD +: 3*CD] = s0_px_q[i*4*CD +: 3*CD];
      st_ea_d[0][i*CD +: CD]     = s0_en_q[i]
                                   ? mix(s0_px_q[i*4*CD + 3*CD +: CD],
                                         s0_ga_q[i*CD +: CD], '0)
                                   : '0;
    end

    for (int k = 0; k < NL; k++) begin
      st_h_d[k+1]     = st_h_q[k];
      st_v_d[k+1]     = st_v_q[k];
      st_blank_d[k+1] = st_blank_q[k];
      if (k + 1 < NL) begin
        st_fg_d[k+1] = st_fg_q[k];
        st_ea_d[k+1] = st_ea_q[k];
      end
      for (int c = 0; c < 3; c++) begin
        st_acc_d[k+1][c*CD +: CD] = mix(st_ea_q[k][k*CD +: CD],
                                        st_fg_q[k][k*3*CD + c*CD +: CD],
                                        st_acc_q[k][c*CD +: CD]);
      end
    end
  end

  // Output register: blanked pixels are forced to black.
  always_comb begin
    h_sync_d = st_h_q[NL];
    v_sync_d = st_v_q[NL];
    rgb_d    = st_blank_q[NL] ? '0 : st_acc_q[NL];
  end

  // All state, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_en_q  <= '1;
      pend_ga_q  <= {NL{MAX}};
      pend_bg_q  <= '0;
      act_en_q   <= '1;
      act_ga_q   <= {NL{MAX}};
      act_bg_q   <= '0;
      vs_prev_q  <= SYNC_IDLE;
      s0_h_q     <= SYNC_IDLE;
      s0_v_q     <= SYNC_IDLE;
      s0_blank_q <= 1'b1;
      s0_px_q    <= '0;
      s0_en_q    <= '1;
      s0_ga_q    <= {NL{MAX}};
      s0_bg_q    <= '0;
      st_h_q     <= {(NL+1){SYNC_IDLE}};
      st_v_q     <= {(NL+1){SYNC_IDLE}};
      st_blank_q <= '1;
      for (int j = 0; j <= NL; j++) st_acc_q[j] <= '0;
      for (int j = 0; j < NL; j++) begin
        st_fg_q[j] <= '0;
        st_ea_q[j] <= '0;
      end
      h_sync_q   <= SYNC_IDLE;
      v_sync_q   <= SYNC_IDLE;
      rgb_q      <= '0;
    end else begin
      pend_en_q  <= pend_en_d;
      pend_ga_q  <= pend_ga_d;
      pend_bg_q  <= pend_bg_d;
      act_en_q   <= act_en_d;
      act_ga_q   <= act_ga_d;
      act_bg_q   <= act_bg_d;
      vs_prev_q  <= vs_prev_d;
      s0_h_q     <= s0_h_d;
      s0_v_q     <= s0_v_d;
      s0_blank_q <= s0_blank_d;
      s0_px_q    <= s0_px_d;
      s0_en_q    <= s0_en_d;
      s0_ga_q    <= s0_ga_d;
      s0_bg_q    <= s0_bg_d;
      st_h_q     <= st_h_d;
      st_v_q     <= st_v_d;
      st_blank_q <= st_blank_d;
      for (int j = 0; j <= NL; j++) st_acc_q[j] <= st_acc_d[j];
      for (int j = 0; j < NL; j++) begin
        st_fg_q[j] <= st_fg_d[j];
        st_ea_q[j] <= st_ea_d[j];
      end
      h_sync_q   <= h_sync_d;
      v_sync_q   <= v_sync_d;
      rgb_q      <= rgb_d;
    end
  end

  assign bus.h_sync = h_sync_q;
  assign bus.v_sync = v_sync_q;
  assign bus.R_out  = rgb_q[0*CD +: CD];
  assign bus.G_out  = rgb_q[1*CD +: CD];
  assign bus.B_out  = rgb_q[2*CD +: CD];
endmodule

// File: tb/tb_reflet_vga_compositor.sv
// Directed bench for reflet_vga_compositor (2 layers, 8-bit, active-low sync).
// Inputs change and outputs are sampled on the falling clock edge; an input
// set at falling edge N is captured on the next rising edge and shows up on
// the outputs at falling edge N+5.
module tb_reflet_vga_compositor;
  localparam int NL = 2;
  localparam int CD = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  reflet_vga_compositor_if #(.n_layers(NL), .color_depth(CD)) bus ();

  reflet_vga_compositor #(
    .n_layers(NL), .color_depth(CD), .sync_active(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rgb(input int r, input int g, input int b);
    return {8'h00, 8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic logic [31:0] out_rgb();
    return {8'h00, bus.R_out, bus.G_out, bus.B_out};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_layer(input int i, input int r, input int g, input int b, input int a);
    bus.layers_in[i*32 +: 32] = {8'(a), 8'(b), 8'(g), 8'(r)};
  endtask

  task automatic cfg_write(input int layer, input logic en, input int alpha);
    bus.cfg_we    = 1'b1;
    bus.cfg_layer = 1'(layer);
    bus.cfg_en    = en;
    bus.cfg_alpha = 8'(alpha);
    tick(1);
    bus.cfg_we    = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.h_sync_in = 1'b1;
    bus.v_sync_in = 1'b1;
    bus.blank_in  = 1'b1;
    bus.layers_in = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_layer = '0;
    bus.cfg_en    = 1'b0;
    bus.cfg_alpha = '0;
    bus.bg_we     = 1'b0;
    bus.bg_rgb    = '0;
    tick(3);
    chk("reset_h", 32'(bus.h_sync), 32'd1);
    chk("reset_v", 32'(bus.v_sync), 32'd1);
    chk("reset_rgb", out_rgb(), rgb(0, 0, 0));

    // alignment and opaque top layer
    reset         = 1'b0;
    bus.blank_in  = 1'b0;
    bus.h_sync_in = 1'b0;
    set_layer(1, 200, 10, 30, 255);
    set_layer(0, 5, 6, 7, 255);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("align_idle_h", 32'(bus.h_sync), 32'd1);
      chk("align_idle_v", 32'(bus.v_sync), 32'd1);
      chk("align_idle_rgb", out_rgb(), rgb(0, 0, 0));
    end
    tick(1);
    chk("align_h", 32'(bus.h_sync), 32'd0);
    chk("opaque", out_rgb(), rgb(200, 10, 30));

    // transparent top layer
    set_layer(1, 200, 10, 30, 0);
    bus.h_sync_in = 1'b1;
    tick(4);
    chk("transp_inflight", out_rgb(), rgb(200, 10, 30));
    tick(1);
    chk("transparent", out_rgb(), rgb(5, 6, 7));
    chk("transp_h", 32'(bus.h_sync), 32'd1);

    // rounding: 128*255/255=128, 128*100/255=50.2 -> 50
    set_layer(0, 5, 6, 7, 0);
    set_layer(1, 255, 0, 100, 128);
    tick(5);
    chk("blend_round", out_rgb(), rgb(128, 0, 50));

    // deferred commit of a layer disable
    set_layer(1, 200, 10, 30, 255);
    set_layer(0, 5, 6, 7, 255);
    tick(5);
    chk("defer_pre", out_rgb(), rgb(200, 10, 30));
    cfg_write(1, 1'b0, 255);
    tick(5);
    chk("defer_hold", out_rgb(), rgb(200, 10, 30));
    bus.v_sync_in = 1'b0;
    tick(4);
    chk("defer_inflight", out_rgb(), rgb(200, 10, 30));
    chk("defer_v_old", 32'(bus.v_sync), 32'd1);
    tick(1);
    chk("defer_commit", out_rgb(), rgb(5, 6, 7));
    chk("defer_v_new", 32'(bus.v_sync), 32'd0);
    bus.v_sync_in = 1'b1;
    tick(2);

    // global alpha 128 on an opaque red layer over black
    cfg_write(1, 1'b1, 128);
    set_layer(1, 255, 0, 0, 255);
    set_layer(0, 5, 6, 7, 0);
    tick(5);
    chk("ga_pending", out_rgb(), rgb(0, 0, 0));
    bus.v_sync_in = 1'b0;
    tick(5);
    chk("ga_commit", out_rgb(), rgb(128, 0, 0));
    bus.v_sync_in = 1'b1;
    tick(2);

    // write on the commit clock waits for the following sync edge
    bus.v_sync_in = 1'b0;
    bus.cfg_we    = 1'b1;
    bus.cfg_layer = 1'b1;
    bus.cfg_en    = 1'b1;
    bus.cfg_alpha = 8'd255;
    tick(1);
    bus.cfg_we    = 1'b0;
    bus.v_sync_in = 1'b1;
    tick(5);
    chk("same_cycle_old", out_rgb(), rgb(128, 0, 0));
    bus.v_sync_in = 1'b0;
    tick(5);
    chk("same_cycle_new", out_rgb(), rgb(255, 0, 0));
    bus.v_sync_in = 1'b1;
    tick(1);

    // background colour, then half-alpha red over it
    bus.bg_we  = 1'b1;
    bus.bg_rgb = {8'd30, 8'd20, 8'd10};
    tick(1);
    bus.bg_we  = 1'b0;
    set_layer(1, 255, 0, 0, 0);
    tick(5);
    chk("bg_pending", out_rgb(), rgb(0, 0, 0));
    bus.v_sync_in = 1'b0;
    tick(5);
    chk("bg_commit", out_rgb(), rgb(10, 20, 30));
    bus.v_sync_in = 1'b1;
    set_layer(1, 255, 0, 0, 128);
    tick(5);
    chk("bg_blend", out_rgb(), rgb(133, 10, 15));

    // blanking
    set_layer(1, 255, 255, 255, 255);
    set_layer(0, 255, 255, 255, 255);
    tick(5);
    chk("white", out_rgb(), rgb(255, 255, 255));
    bus.blank_in = 1'b1;
    tick(4);
    chk("blank_inflight", out_rgb(), rgb(255, 255, 255));
    tick(1);
    chk("blank", out_rgb(), rgb(0, 0, 0));

    // reset mid-line
    bus.blank_in  = 1'b0;
    bus.h_sync_in = 1'b0;
    tick(5);
    chk("pre_reset_h", 32'(bus.h_sync), 32'd0);
    chk("pre_reset_rgb", out_rgb(), rgb(255, 255, 255));
    reset = 1'b1;
    tick(1);
    chk("midreset_rgb", out_rgb(), rgb(0, 0, 0));
    chk("midreset_h", 32'(bus.h_sync), 32'd1);
    chk("midreset_v", 32'(bus.v_sync), 32'd1);
    tick(2);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("post_reset_rgb", out_rgb(), rgb(0, 0, 0));
      chk("post_reset_h", 32'(bus.h_sync), 32'd1);
    end
    tick(1);
    chk("post_reset_data", out_rgb(), rgb(255, 255, 255));
    chk("post_reset_h_data", 32'(bus.h_sync), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
